perceptron_backprop: RTL and testbench

Sequential weight-update engine for one perceptron: the backward direction of the forward activation path. It takes a latched forward result (activation output `y`), a target, a learning rate and the perceptron's inputs and weights. It computes `delta = lr * (t - y) * f'(y)` in Q32.32 fixed point, then streams out the updated weights `w[i] + delta*x[i]` and bias `b + delta` over a valid/ready interface. It sits beside the forward perceptron datapath and writes into the weight store.

---
 rtl/perceptron_backprop_if.sv | 24 ++
 rtl/perceptron_backprop.sv | 222 ++++++++++++++++++++++
 tb/tb_perceptron_backprop.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_backprop_if.sv
// Output beat channel of the perceptron weight-update engine: valid/ready with index and data.
// The master drives valid/idx/data; the slave drives ready.
interface perceptron_backprop_if #(
  parameter int unsigned IdxW = 3
) ();
  logic            out_valid;
  logic            out_ready;
  logic [IdxW-1:0] out_idx;
  logic [63:0]     out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/perceptron_backprop.sv
// Perceptron backward pass: delta = lr*(t-y)*f'(y) in signed Q32.32, then streams w[i]+delta*x[i]
// and b+delta. Define PERCEPTRON_BACKPROP_SAT_EN to saturate every multiply and add/sub result.
module perceptron_backprop #(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned FRAC_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [1:0]             act_sel_i,
  input  logic [63:0]            y_i,
  input  logic [63:0]            target_i,
  input  logic [63:0]            lr_i,
  input  logic [64*N_INPUTS-1:0] x_i,
  input  logic [64*N_INPUTS-1:0] w_i,
  input  logic [63:0]            b_i,
  output logic                   busy_o,
  output logic                   done_o,
  perceptron_backprop_if.master  out_if
);

  localparam int unsigned IdxW = $clog2(N_INPUTS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_INPUTS);
  localparam logic [63:0] One  = 64'd1 << FRAC_BITS;
  localparam logic [63:0] SMax = {1'b0, {63{1'b1}}};
  localparam logic [63:0] SMin = {1'b1, {63{1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StErr, StDeriv, StGain, StScale, StStream, StDone
  } state_e;

  function automatic logic [63:0] fx_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    logic signed [127:0] s;
`endif
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    s = p >>> FRAC_BITS;
    // Result fits only if bits 127..63 are all copies of the sign.
    if (s[127:63] != {65{s[127]}}) return s[127] ? SMin : SMax;
    return s[63:0];
`else
    return 64'(p >>> FRAC_BITS);
`endif
  endfunction

  function automatic logic [63:0] fx_add(input logic [63:0] a, input logic [63:0] b);
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    logic [64:0] s;
    s = {a[63], a} + {b[63], b};
    if (s[64] != s[63]) return s[64] ? SMin : SMax;
    return s[63:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [63:0] fx_sub(input logic [63:0] a, input logic [63:0] b);
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    logic [64:0] s;
    s = {a[63], a} - {b[63], b};
    if (s[64] != s[63]) return s[64] ? SMin : SMax;
    return s[63:0];
`else
    return a - b;
`endif
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            act_q, act_d;
  logic [63:0]           y_q, y_d;
  logic [63:0]           t_q, t_d;
  logic [63:0]           lr_q, lr_d;
  logic [64*N_INPUTS-1:0] x_q, x_d;
  logic [64*N_INPUTS-1:0] w_q, w_d;
  logic [63:0]           b_q, b_d;
  logic [63:0]           err_q, err_d;
  logic [63:0]           fp_q, fp_d;
  logic [63:0]           g_q, g_d;
  logic [63:0]           delta_q, delta_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [63:0]           out_data_q, out_data_d;

  logic [63:0]     delta_new;
  logic [63:0]     delta_use;
  logic [IdxW-1:0] beat_idx;
  logic [63:0]     sel_w;
  logic [63:0]     sel_x;
  logic            is_bias;
  logic [63:0]     beat_val;

  // Next beat value: beat 0 while leaving SCALE (using the fresh delta), else idx+1.
  always_comb begin
    delta_new = fx_mul(lr_q, g_q);
    delta_use = (state_q == StStream) ? delta_q : delta_new;
    beat_idx  = (state_q == StStream) ? idx_q + 1'b1 : '0;
    sel_w     = b_q;
    sel_x     = '0;
    is_bias   = 1'b1;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (beat_idx == IdxW'(i)) begin
        sel_w   = w_q[64*i +: 64];
        sel_x   = x_q[64*i +: 64];
        is_bias = 1'b0;
      end
    end
    beat_val = is_bias ? fx_add(sel_w, delta_use) : fx_add(sel_w, fx_mul(delta_use, sel_x));
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    y_d        = y_q;
    t_d        = t_q;
    lr_d       = lr_q;
    x_d        = x_q;
    w_d        = w_q;
    b_d        = b_q;
    err_d      = err_q;
    fp_d       = fp_q;
    g_d        = g_q;
    delta_d    = delta_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          act_d   = act_sel_i;
          y_d     = y_i;
          t_d     = target_i;
          lr_d    = lr_i;
          x_d     = x_i;
          w_d     = w_i;
          b_d     = b_i;
          idx_d   = '0;
          state_d = StErr;
        end
      end
      StErr: begin
        err_d   = fx_sub(t_q, y_q);
        state_d = StDeriv;
      end
      StDeriv: begin
        unique case (act_q)
          2'd0:    fp_d = One;
          2'd1:    fp_d = fx_mul(y_q, fx_sub(One, y_q));
          2'd2:    fp_d = fx_sub(One, fx_mul(y_q, y_q));
          default: fp_d = ($signed(y_q) > 64'sd0) ? One : '0;
        endcase
        state_d = StGain;
      end
      StGain: begin
        g_d     = fx_mul(err_q, fp_q);
        state_d = StScale;
      end
      StScale: begin
        delta_d    = delta_new;
        idx_d      = '0;
        out_data_d = beat_val;
        state_d    = StStream;
      end
      StStream: begin
        if (out_if.out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d      = idx_q + 1'b1;
            out_data_d = beat_val;
          end
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      act_q      <= '0;
      y_q        <= '0;
      t_q        <= '0;
      lr_q       <= '0;
      x_q        <= '0;
      w_q        <= '0;
      b_q        <= '0;
      err_q      <= '0;
      fp_q       <= '0;
      g_q        <= '0;
      delta_q    <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      y_q        <= y_d;
      t_q        <= t_d;
      lr_q       <= lr_d;
      x_q        <= x_d;
      w_q        <= w_d;
      b_q        <= b_d;
      err_q      <= err_d;
      fp_q       <= fp_d;
      g_q        <= g_d;
      delta_q    <= delta_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
    end
  end

  // All outputs decode from registers only; out_ready never reaches an output combinationally.
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);
  assign out_if.out_valid = (state_q == StStream);
  assign out_if.out_idx   = idx_q;
  assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_perceptron_backprop.sv
// Self-checking bench for perceptron_backprop: directed cases plus randomized transactions
// compared against a plain-arithmetic reference model of the update rule.
module tb_perceptron_backprop;
  localparam int unsigned N    = 4;
  localparam int unsigned FB   = 32;
  localparam int unsigned IdxW = 3;
  localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       act;
  logic [63:0]      y, t, lr, b;
  logic [64*N-1:0]  x, w;
  logic             busy, done;

  perceptron_backprop_if #(.IdxW(IdxW)) bus ();

  perceptron_backprop #(.N_INPUTS(N), .FRAC_BITS(FB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .act_sel_i (act),
    .y_i       (y),
    .target_i  (t),
    .lr_i      (lr),
    .x_i       (x),
    .w_i       (w),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_b [N+1];
  logic [63:0] got_data [$];
  int          got_idx [$];
  int          first_valid, done_cyc, viol, overlap, busy_bad;
  bit          timeout;

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_mul(input logic signed [63:0] a, input logic signed [63:0] c);
    logic signed [127:0] p;
    p = 128'(a) * 128'(c);
    p = p >>> FB;
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    if (p > 128'sh7FFF_FFFF_FFFF_FFFF) return MAXV;
    if (p < -128'sh8000_0000_0000_0000) return MINV;
`endif
    return p[63:0];
  endfunction

  function automatic logic [63:0] m_add(input logic signed [63:0] a, input logic signed [63:0] c);
    logic signed [64:0] s;
    s = 65'(a) + 65'(c);
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) return MAXV;
    if (s < -65'sh0_8000_0000_0000_0000) return MINV;
`endif
    return s[63:0];
  endfunction

  function automatic logic [63:0] m_sub(input logic signed [63:0] a, input logic signed [63:0] c);
    logic signed [64:0] s;
    s = 65'(a) - 65'(c);
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) return MAXV;
    if (s < -65'sh0_8000_0000_0000_0000) return MINV;
`endif
    return s[63:0];
  endfunction

  task automatic model(input logic [1:0] a, input logic [63:0] yy, input logic [63:0] tt,
                       input logic [63:0] ll, input logic [64*N-1:0] xx,
                       input logic [64*N-1:0] ww, input logic [63:0] bb);
    logic [63:0] e, fp, d;
    e = m_sub(tt, yy);
    case (a)
      2'd0:    fp = ONE;
      2'd1:    fp = m_mul(yy, m_sub(ONE, yy));
      2'd2:    fp = m_sub(ONE, m_mul(yy, yy));
      default: fp = ($signed(yy) > 0) ? ONE : 64'd0;
    endcase
    d = m_mul(ll, m_mul(e, fp));
    for (int k = 0; k < N; k++) exp_b[k] = m_add(ww[64*k +: 64], m_mul(d, xx[64*k +: 64]));
    exp_b[N] = m_add(bb, d);
  endtask

  function automatic logic [63:0] rnd_fx();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) r = {{28{r[35]}}, r[35:0]};
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_txn(input logic [1:0] a, input logic [63:0] yy, input logic [63:0] tt,
                           input logic [63:0] ll, input logic [64*N-1:0] xx,
                           input logic [64*N-1:0] ww, input logic [63:0] bb);
    model(a, yy, tt, ll, xx, ww, bb);
    act = a; y = yy; t = tt; lr = ll; x = xx; w = ww; b = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs: they must have been latched on the accepting edge.
    act = 2'($urandom); y = rnd_fx(); t = rnd_fx(); lr = rnd_fx(); b = rnd_fx();
    for (int k = 0; k < N; k++) begin
      x[64*k +: 64] = rnd_fx();
      w[64*k +: 64] = rnd_fx();
    end
  endtask

  // mode 0: ready always; 1: random ready; 2: ready low for hold_len cycles while idx hold_idx valid
  task automatic collect(input int mode, input int hold_idx, input int hold_len);
    int          held;
    bit          pv, pr;
    logic [63:0] pd;
    int          pi;
    held = 0; pv = 0; pr = 0; pd = '0; pi = 0;
    got_data.delete(); got_idx.delete();
    first_valid = -1; done_cyc = -1; viol = 0; overlap = 0; busy_bad = 0; timeout = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (mode == 0) bus.out_ready = 1'b1;
      else if (mode == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
      else if (bus.out_valid && int'(bus.out_idx) == hold_idx && held < hold_len) begin
        bus.out_ready = 1'b0;
        held++;
      end else bus.out_ready = 1'b1;
      if (pv && !pr && (!bus.out_valid || int'(bus.out_idx) != pi || bus.out_data !== pd)) viol++;
      if (bus.out_valid && done) overlap++;
      if (!busy) busy_bad++;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_idx.push_back(int'(bus.out_idx));
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pi = int'(bus.out_idx);
      if (done) begin
        done_cyc = cyc;
        @(negedge clk);
        bus.out_ready = 1'b1;
        if (busy || done || bus.out_valid) busy_bad++;
        return;
      end
    end
    timeout = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.out_ready = 1'b1;
    act = '0; y = '0; t = '0; lr = '0; x = '0; w = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, bus.out_valid, bus.out_idx, bus.out_data, done} !== '0) begin
      failures++;
      $display("FAIL reset_values got busy=%b valid=%b idx=%0d data=%h done=%b need all 0",
               busy, bus.out_valid, bus.out_idx, bus.out_data, done);
    end
    // Reset dominates a simultaneous start.
    start = 1'b1; act = 2'd0; t = ONE; lr = ONE;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_vs_start busy=%b need 0", busy);
    end
  endtask

  task automatic test_step();
    logic [63:0] e [N+1];
    e[0] = 64'h0000_0000_8000_0000; e[1] = 64'h0000_0001_0000_0000;
    e[2] = 64'hFFFF_FFFF_8000_0000; e[3] = 64'h0;  e[4] = 64'h0000_0000_8000_0000;
    start_txn(2'd0, 64'd0, ONE, 64'h8000_0000,
              {64'd0, 64'hFFFF_FFFF_0000_0000, 64'h2_0000_0000, ONE}, '0, '0);
    collect(0, 0, 0);
    checks++;
    if (timeout || got_data.size() != N + 1) begin
      failures++;
      $display("FAIL step_count beats=%0d need=%0d timeout=%0d", got_data.size(), N + 1, timeout);
    end
    for (int k = 0; k < got_data.size() && k <= N; k++) begin
      checks++;
      if (got_data[k] !== e[k] || got_idx[k] != k) begin
        failures++;
        $display("FAIL step_beat%0d got idx=%0d data=%h need idx=%0d data=%h",
                 k, got_idx[k], got_data[k], k, e[k]);
      end
    end
    checks++;
    if (first_valid != 5 || done_cyc != 10) begin
      failures++;
      $display("FAIL step_timing first_valid=%0d done=%0d need 5 and 10", first_valid, done_cyc);
    end
    checks++;
    if (busy_bad != 0 || overlap != 0) begin
      failures++;
      $display("FAIL step_flags busy_bad=%0d overlap=%0d need 0 0", busy_bad, overlap);
    end
  endtask

  task automatic test_sigmoid_tanh();
    start_txn(2'd1, 64'h8000_0000, ONE, ONE, {192'd0, ONE}, '0, '0);
    collect(1, 0, 0);
    checks++;
    if (got_data.size() < 1 || got_data[0] !== 64'h2000_0000) begin
      failures++;
      $display("FAIL sigmoid_beat0 got=%h need=%h", (got_data.size() > 0) ? got_data[0] : 64'hx,
               64'h2000_0000);
    end
    start_txn(2'd2, 64'd0, 64'hC000_0000, ONE, {192'd0, 64'h2_0000_0000}, '0, '0);
    collect(0, 0, 0);
    checks++;
    if (got_data.size() < 1 || got_data[0] !== 64'h1_8000_0000) begin
      failures++;
      $display("FAIL tanh_beat0 got=%h need=%h", (got_data.size() > 0) ? got_data[0] : 64'hx,
               64'h1_8000_0000);
    end
  endtask

  task automatic test_relu();
    logic [64*N-1:0] xx, ww;
    logic [63:0]     bb, yv;
    for (int r = 0; r < 2; r++) begin
      yv = (r == 0) ? 64'hFFFF_FFFF_0000_0000 : 64'd0;
      for (int k = 0; k < N; k++) begin
        xx[64*k +: 64] = rnd_fx();
        ww[64*k +: 64] = rnd_fx();
      end
      bb = rnd_fx();
      start_txn(2'd3, yv, rnd_fx(), rnd_fx(), xx, ww, bb);
      collect(1, 0, 0);
      for (int k = 0; k <= N; k++) begin
        checks++;
        if (k >= got_data.size() || got_data[k] !== ((k == N) ? bb : ww[64*k +: 64])) begin
          failures++;
          $display("FAIL relu%0d_beat%0d got=%h need=%h", r, k,
                   (k < got_data.size()) ? got_data[k] : 64'hx, (k == N) ? bb : ww[64*k +: 64]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [64*N-1:0] xx, ww;
    for (int k = 0; k < N; k++) begin
      xx[64*k +: 64] = rnd_fx();
      ww[64*k +: 64] = rnd_fx();
    end
    start_txn(2'd1, rnd_fx(), rnd_fx(), rnd_fx(), xx, ww, rnd_fx());
    collect(2, 2, 3);
    checks++;
    if (done_cyc != 13 || viol != 0 || got_data.size() != N + 1) begin
      failures++;
      $display("FAIL bp_timing done=%0d viol=%0d beats=%0d need 13 0 %0d",
               done_cyc, viol, got_data.size(), N + 1);
    end
    for (int k = 0; k < got_data.size() && k <= N; k++) begin
      checks++;
      if (got_data[k] !== exp_b[k] || got_idx[k] != k) begin
        failures++;
        $display("FAIL bp_beat%0d got idx=%0d data=%h need idx=%0d data=%h",
                 k, got_idx[k], got_data[k], k, exp_b[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      start_txn(2'($urandom), rnd_fx(), rnd_fx(), rnd_fx(), {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()},
                {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()}, rnd_fx());
      collect(0, 0, 0);
      checks++;
      if (first_valid != 5 || done_cyc != 10 || busy_bad != 0) begin
        failures++;
        $display("FAIL b2b%0d_timing first_valid=%0d done=%0d busy_bad=%0d need 5 10 0",
                 r, first_valid, done_cyc, busy_bad);
      end
      checks++;
      if (got_data.size() != N + 1 || got_data[N] !== exp_b[N]) begin
        failures++;
        $display("FAIL b2b%0d_bias beats=%0d got=%h need=%h", r, got_data.size(),
                 (got_data.size() > N) ? got_data[N] : 64'hx, exp_b[N]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    start_txn(2'd0, 64'd0, ONE, ONE, {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()}, '0, '0);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (!bus.out_valid || bus.out_idx !== 3'd1 || !busy) begin
      failures++;
      $display("FAIL start_ignored valid=%b idx=%0d busy=%b need 1 1 1",
               bus.out_valid, bus.out_idx, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, bus.out_valid, bus.out_idx, bus.out_data, done} !== '0) begin
      failures++;
      $display("FAIL mid_reset got busy=%b valid=%b idx=%0d data=%h done=%b need all 0",
               busy, bus.out_valid, bus.out_idx, bus.out_data, done);
    end
    rst = 1'b0;
    start_txn(2'd2, rnd_fx(), rnd_fx(), rnd_fx(), {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()},
              {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()}, rnd_fx());
    collect(0, 0, 0);
    checks++;
    if (first_valid != 5 || got_data.size() != N + 1 || got_idx[0] != 0) begin
      failures++;
      $display("FAIL restart first_valid=%0d beats=%0d need 5 %0d", first_valid,
               got_data.size(), N + 1);
    end
    for (int k = 0; k < got_data.size() && k <= N; k++) begin
      checks++;
      if (got_data[k] !== exp_b[k]) begin
        failures++;
        $display("FAIL restart_beat%0d got=%h need=%h", k, got_data[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [63:0] need0;
`ifdef PERCEPTRON_BACKPROP_SAT_EN
    need0 = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    need0 = 64'h8000_0000_FFFF_FFFF;
`endif
    start_txn(2'd0, 64'd0, ONE, ONE, {rnd_fx(), rnd_fx(), rnd_fx(), ONE},
              {rnd_fx(), rnd_fx(), rnd_fx(), MAXV}, rnd_fx());
    collect(0, 0, 0);
    checks++;
    if (got_data.size() < 1 || got_data[0] !== need0) begin
      failures++;
      $display("FAIL sat_beat0 got=%h need=%h", (got_data.size() > 0) ? got_data[0] : 64'hx, need0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      start_txn(2'($urandom), rnd_fx(), rnd_fx(), rnd_fx(), {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()},
                {rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx()}, rnd_fx());
      collect(1, 0, 0);
      checks++;
      if (timeout || got_data.size() != N + 1 || viol != 0 || overlap != 0 || busy_bad != 0) begin
        failures++;
        $display("FAIL rand%0d_proto beats=%0d viol=%0d overlap=%0d busy_bad=%0d timeout=%0d",
                 r, got_data.size(), viol, overlap, busy_bad, timeout);
      end
      for (int k = 0; k < got_data.size() && k <= N; k++) begin
        checks++;
        if (got_data[k] !== exp_b[k] || got_idx[k] != k) begin
          failures++;
          $display("FAIL rand%0d_beat%0d got idx=%0d data=%h need idx=%0d data=%h",
                   r, k, got_idx[k], got_data[k], k, exp_b[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_sigmoid_tanh();
    test_relu();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
